univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the single-bit serial-in/serial-out register.
- Manual modes, selected each cycle: hold, shift right, shift left, parallel load.
- Burst engine: a start pulse runs a counted, automatic shift of LEN bits in a latched direction, reporting busy and a done pulse.
- Sits between parallel datapath words and serial links (serializer, deserializer or delay line).

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, burst-length/counter width; must satisfy 2^CNT_W-1 >= WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  enable for manual modes; ignored while busy
mode  input  2  manual op: 00 hold, 01 shift right, 10 shift left, 11 parallel load
sin_r  input  1  serial bit entering q[WIDTH-1] on right shifts (manual and burst)
sin_l  input  1  serial bit entering q[0] on left shifts (manual and burst)
pin  input  WIDTH  parallel load data
start  input  1  burst request, single-cycle pulse
dir  input  1  burst direction, sampled with start: 0 right, 1 left
len  input  CNT_W  burst shift count, sampled with start
q  output  WIDTH  register contents
sout_r  output  1  q[0] (right-shift serial out)
sout_l  output  1  q[WIDTH-1] (left-shift serial out)
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion
bit_cnt  output  CNT_W  shifts remaining in current burst

Behaviour:
- Reset:
  - rst sampled high: q=0, busy=0, done=0, bit_cnt=0, FSM=IDLE.
  - Reset overrides all other inputs in that cycle, including mid-burst. No done pulse is produced for an aborted burst.
- Shift right: q <= {sin_r, q[WIDTH-1:1]}.
- Shift left: q <= {q[WIDTH-2:0], sin_l}.
- sout_r and sout_l are combinational from registered q; there is no extra latency.
- FSM states: IDLE, SHIFT.
- IDLE:
  - start=1, len!=0: latch dir and len into bit_cnt; busy=1 next cycle; go to SHIFT. q is NOT modified in the start cycle (start beats mode/en).
  - start=1, len=0: done=1 next cycle; busy stays 0; q unchanged; stay IDLE.
  - start=0, en=1: apply mode. The result is visible on q after the edge.
  - start=0, en=0: hold q.
  - done=0 except the cases above.
- SHIFT:
  - Each cycle, shift once in the latched direction, using the live sin_r/sin_l value, and decrement bit_cnt.
  - When the shift decrements bit_cnt to 0: go to IDLE, busy=0, done=1, all on the same edge.
  - A len-N burst therefore gives busy high for exactly N cycles. done is high for the one cycle after the Nth shift edge.
  - start, dir, len, en, mode and pin are ignored while busy. A start in the done cycle is accepted, giving a back-to-back burst.
- len > WIDTH is legal: the register shifts len times and contents are fully replaced by serial input.
- bit_cnt is 0 whenever IDLE.
- No X propagation: every register has a defined reset and update on every path.

Test Plan:
1. rst=1 for 2 cycles with en=1, mode=11, pin=8'hA5, start=1 -> q=8'h00, busy=0, done=0, bit_cnt=0 throughout; first post-reset load gives q=8'hA5.
2. Load 8'hA5 (en=1, mode=11), then mode=01, sin_r=1 for 3 cycles -> q=D2, E9, F4; sout_r=0, 1, 0. Then mode=00 -> q holds F4.
3. Load 8'h81; start=1, dir=1, len=3, sin_l=0 -> q unchanged in start cycle. Then busy=1 for 3 cycles with q=02, 04, 08 and bit_cnt=2, 1, 0. done=1 for exactly one cycle with busy=0.
4. start=1, len=0 -> done pulses one cycle, busy never rises, q unchanged. Second start (and en=1, mode=11) during a len=4 burst -> ignored; burst completes in 4 cycles with exactly one done.
5. Load 8'hFF; len=5 burst, dir=0, rst asserted in 2nd busy cycle -> next cycle q=00, busy=0, bit_cnt=0; no done pulse in following 10 cycles.
6. Load 8'h3C; len=10 (>WIDTH), dir=0, sin_r toggling 1,0,… starting 1 -> q=8'h55 after burst, busy 10 cycles, single done; back-to-back start in the done cycle accepted.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: per-cycle hold/shift-right/shift-left/load, plus a
// counted burst engine that shifts len bits in a latched direction.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                   input logic in_bit);
    return {in_bit, v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                  input logic in_bit);
    return {v[WIDTH-2:0], in_bit};
  endfunction

  // Next-state logic: start takes priority over manual modes while idle.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != {CNT_W{1'b0}}) begin
            state_d = SHIFT;
            cnt_d   = len;
            dir_d   = dir;
          end else begin
            done_d = 1'b1;
          end
        end else if (en) begin
          case (mode)
            MODE_HOLD:  q_d = q_q;
            MODE_RIGHT: q_d = shift_right(q_q, sin_r);
            MODE_LEFT:  q_d = shift_left(q_q, sin_l);
            MODE_LOAD:  q_d = pin;
            default:    q_d = q_q;
          endcase
        end else begin
          q_d = q_q;
        end
      end
      SHIFT: begin
        if (dir_q) begin
          q_d = shift_left(q_q, sin_l);
        end else begin
          q_d = shift_right(q_q, sin_r);
        end
        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        // The final shift returns to idle and raises done on the same edge.
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers with synchronous reset that aborts any burst silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign q       = q_q;
  assign sout_r  = q_q[0];
  assign sout_l  = q_q[WIDTH-1];
  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a model.
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         sin_r;
  logic         sin_l;
  logic [W-1:0] pin;
  logic         start;
  logic         dir;
  logic [C-1:0] len;
  logic [W-1:0] q;
  logic         sout_r;
  logic         sout_l;
  logic         busy;
  logic         done;
  logic [C-1:0] bit_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: what the register must hold after each edge.
  logic [W-1:0] m_q    = '0;
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  bit           m_dir  = 1'b0;
  int           m_rem  = 0;

  univ_shift_reg #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pin(pin), .start(start), .dir(dir), .len(len), .q(q), .sout_r(sout_r),
    .sout_l(sout_l), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference behaviour evaluated from the inputs present at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_q = '0; m_busy = 0; m_done = 0; m_rem = 0; m_dir = 0;
    end else if (m_busy) begin
      if (m_dir) m_q = (m_q << 1) | W'(sin_l);
      else       m_q = (m_q >> 1) | (W'(sin_r) << (W - 1));
      m_rem  = m_rem - 1;
      m_busy = (m_rem != 0);
      m_done = (m_rem == 0);
    end else begin
      m_done = 0;
      if (start) begin
        if (len == 0) m_done = 1;
        else begin
          m_busy = 1; m_rem = int'(len); m_dir = dir;
        end
      end else if (en) begin
        case (mode)
          2'd1:    m_q = (m_q >> 1) | (W'(sin_r) << (W - 1));
          2'd2:    m_q = (m_q << 1) | W'(sin_l);
          2'd3:    m_q = pin;
          default: m_q = m_q;
        endcase
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("q", 32'(q), 32'(m_q));
    chk("sout_r", 32'(sout_r), 32'(m_q % 2));
    chk("sout_l", 32'(sout_l), 32'(m_q / (2 ** (W - 1))));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("bit_cnt", 32'(bit_cnt), 32'(m_rem));
  end

  task automatic load(input logic [W-1:0] v);
    start = 1'b0; en = 1'b1; mode = 2'd3; pin = v;
    step();
    en = 1'b0;
  endtask

  initial begin
    int nb;
    int nd;
    rst = 1'b1; en = 1'b1; mode = 2'd3; pin = 8'hA5; start = 1'b1;
    sin_r = 1'b0; sin_l = 1'b0; dir = 1'b0; len = 4'd3;

    // Reset dominates a simultaneous load and start.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_cnt", 32'(bit_cnt), 32'h0);
    end
    rst = 1'b0; start = 1'b0;
    step();
    chk("first_load", 32'(q), 32'hA5);

    // Manual right shifts with sin_r=1, then hold.
    mode = 2'd1; sin_r = 1'b1;
    step(); chk("shr1", 32'(q), 32'hD2); chk("shr1_sout", 32'(sout_r), 32'h0);
    step(); chk("shr2", 32'(q), 32'hE9); chk("shr2_sout", 32'(sout_r), 32'h1);
    step(); chk("shr3", 32'(q), 32'hF4); chk("shr3_sout", 32'(sout_r), 32'h0);
    mode = 2'd0;
    step(); chk("hold", 32'(q), 32'hF4);

    // Left burst of 3 from 0x81.
    load(8'h81);
    start = 1'b1; dir = 1'b1; len = 4'd3; sin_l = 1'b0;
    step(); start = 1'b0;
    chk("burst_start_q", 32'(q), 32'h81); chk("burst_start_cnt", 32'(bit_cnt), 32'd3);
    step(); chk("burst_q1", 32'(q), 32'h02);
    step(); chk("burst_q2", 32'(q), 32'h04);
    step(); chk("burst_end_q", 32'(q), 32'h08);
    chk("burst_end_done", 32'(done), 32'h1); chk("burst_end_busy", 32'(busy), 32'h0);
    step(); chk("burst_done_once", 32'(done), 32'h0);

    // Zero-length burst gives a lone done.
    start = 1'b1; len = 4'd0;
    step(); start = 1'b0;
    chk("len0_done", 32'(done), 32'h1); chk("len0_busy", 32'(busy), 32'h0);
    chk("len0_q", 32'(q), 32'h08);

    // len=4 burst with start/load requests held during it.
    start = 1'b1; len = 4'd4; dir = 1'b0; sin_r = 1'b0;
    step();
    nb = busy ? 1 : 0; nd = 0;
    en = 1'b1; mode = 2'd3; pin = 8'h00; len = 4'd2;
    for (int i = 0; i < 3; i++) begin
      step(); nb += busy ? 1 : 0; nd += done ? 1 : 0;
    end
    start = 1'b0; en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(); nb += busy ? 1 : 0; nd += done ? 1 : 0;
    end
    chk("len4_busy_cycles", 32'(nb), 32'd4); chk("len4_done_count", 32'(nd), 32'd1);

    // Reset in the second busy cycle aborts without done.
    load(8'hFF);
    start = 1'b1; len = 4'd5; dir = 1'b0;
    step(); start = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    chk("abort_q", 32'(q), 32'h00); chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_cnt", 32'(bit_cnt), 32'h0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      step(); nd += done ? 1 : 0;
    end
    chk("abort_no_done", 32'(nd), 32'd0);

    // Burst longer than the register, then back-to-back start in the done cycle.
    load(8'h3C);
    start = 1'b1; len = 4'd10; dir = 1'b0;
    step(); start = 1'b0;
    nb = 1;
    for (int k = 0; k < 10; k++) begin
      sin_r = (k % 2 == 0);
      step(); nb += busy ? 1 : 0;
    end
    chk("long_q", 32'(q), 32'h55); chk("long_done", 32'(done), 32'h1);
    chk("long_busy_cycles", 32'(nb), 32'd10);
    start = 1'b1; len = 4'd2; dir = 1'b1; sin_l = 1'b1;
    step(); start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'h1); chk("b2b_cnt", 32'(bit_cnt), 32'd2);
    step(); step();
    chk("b2b_q", 32'(q), 32'h57); chk("b2b_done", 32'(done), 32'h1);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(63) == 0);
      start = ($urandom_range(7) == 0);
      en    = 1'($urandom);
      mode  = 2'($urandom);
      sin_r = 1'($urandom);
      sin_l = 1'($urandom);
      pin   = W'($urandom);
      dir   = 1'($urandom);
      len   = C'($urandom);
      step();
    end
    rst = 1'b0; start = 1'b0; en = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
